ucie_ctl_tx_fsm: RTL
====================

Name: ucie_ctl_tx_fsm

Overview:
- Transmit-side control FSM for the UCIe controller; counterpart of the RX buffer/overflow FSM.
- Gates reads from the TX buffer onto the link using credit-based flow control, so the remote RX buffer cannot overflow.
- Reacts to overflow reports from the remote receiver with a timed error hold, then returns to idle.
- Sits between the TX buffer (read side) and the link/sideband interface.

Parameters:
CREDIT_MAX, 8, number of remote RX buffer entries (credits granted at idle/reload)
CREDIT_W, 4, width of the credit counter; must hold CREDIT_MAX
ERR_HOLD, 4, cycles spent in ERROR asserting o_overflow_detected (>=1)

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous reset, active-high
i_state_request  input  4  link state request; any nonzero value = run, 0 = idle
i_buffer_empty  input  1  TX buffer empty flag
i_credit_return  input  1  one-cycle pulse; remote RX freed one entry
i_overflow_detected  input  1  remote RX reported overflow (level, sampled each cycle)
o_buffer_read_enable  output  1  pop one entry from the TX buffer this cycle
o_tx_valid  output  1  link data valid; buffer data (1-cycle read latency) on link
o_credit_count  output  CREDIT_W  current available credits
o_overflow_detected  output  1  high while in ERROR
o_credit_error  output  1  one-cycle pulse: credit return while counter already at CREDIT_MAX
o_state  output  4  one-hot state: IDLE=0001, ACTIVE=0010, STALL=0100, ERROR=1000

Behaviour:
- Reset (i_rst high at posedge) state and outputs:
  - state IDLE, credits=CREDIT_MAX, error counter 0.
  - o_tx_valid=0, o_credit_error=0, o_buffer_read_enable=0, o_overflow_detected=0, o_state=0001.
- issue = (state==ACTIVE) && !i_buffer_empty && (credits!=0).
  - o_buffer_read_enable = issue. Combinational from registered state and the inputs.
  - o_tx_valid is registered and equals issue delayed by exactly 1 cycle. It does so in every state, so a read issued in the last ACTIVE cycle still produces valid on the next cycle.
- Credit update applies in ACTIVE and STALL only: credits_next = credits - issue + i_credit_return.
  - Simultaneous issue and return: count unchanged.
  - Return with credits==CREDIT_MAX and no issue: count stays CREDIT_MAX and o_credit_error pulses for 1 cycle (registered).
- Credits are held at CREDIT_MAX in IDLE. Credit returns are ignored in IDLE and ERROR, with no o_credit_error.
- Transition priority per cycle: overflow > request drop > credit conditions.
- IDLE -> ACTIVE when i_state_request!=0. Otherwise stay.
- ACTIVE:
  - -> ERROR if i_overflow_detected.
  - else -> IDLE if i_state_request==0.
  - else -> STALL if credits_next==0.
  - else stay.
- STALL (no reads issued):
  - -> ERROR if i_overflow_detected.
  - else -> IDLE if request==0.
  - else -> ACTIVE on i_credit_return.
- ERROR:
  - o_overflow_detected=1 and no reads issued.
  - Counter counts ERR_HOLD cycles. After ERR_HOLD cycles in ERROR -> IDLE (credits reloaded to CREDIT_MAX), regardless of request or overflow inputs.
- Request drop with credits outstanding: go to IDLE and reload credits (the link-level reset implies the remote buffer is flushed).
- i_state_request value other than 0 carries no further meaning in this block.
- o_credit_count reflects the registered counter.

Test Plan:
- Reset, then request=4'h1 with buffer non-empty and no credit returns:
  - IDLE->ACTIVE; 8 consecutive read enables; o_tx_valid high for 8 cycles, each 1 cycle after its read.
  - credit count 8->0; state STALL (0100); reads stop.
- In STALL, one i_credit_return pulse -> ACTIVE next cycle; exactly 1 read issued; back to STALL with count 0.
- In ACTIVE with count 5, issue and credit return on the same cycle -> count stays 5, no o_credit_error. Then a return at count 8 with buffer empty -> o_credit_error pulses once, count stays 8.
- i_overflow_detected for 1 cycle in ACTIVE:
  - ERROR; o_overflow_detected high exactly 4 cycles; read enable low throughout.
  - then IDLE with count 8; overflow asserted together with request=0 still goes to ERROR.
- request drops to 0 on the same cycle as a read in ACTIVE -> next state IDLE, o_tx_valid still pulses 1 cycle later, count reloads to 8.
- Assert i_rst mid-STALL with count 0 -> next cycle IDLE, count 8, all outputs at reset values.

Source files
------------

// File: rtl/ucie_ctl_tx_fsm.sv
// ---------------------------------------------------------------------------
// ucie_ctl_tx_fsm
//
// Transmit-side control FSM for the UCIe controller. It decides when a word
// may be popped from the TX buffer and put on the link, using credit-based
// flow control so the remote RX buffer can never overflow. If the remote
// receiver still reports an overflow, the FSM holds in ERROR for a fixed
// number of cycles and then falls back to IDLE with a full credit reload.
//
// Ports
//   i_clk                 clock
//   i_rst                 synchronous reset, active-high
//   i_state_request[3:0]  link state request; nonzero = run, zero = idle
//   i_buffer_empty        TX buffer empty flag
//   i_credit_return       one-cycle pulse: remote RX freed one entry
//   i_overflow_detected   remote RX overflow report (level)
//   o_buffer_read_enable  pop one TX buffer entry this cycle (combinational)
//   o_tx_valid            link data valid, one cycle after the pop
//   o_credit_count        registered credit counter
//   o_overflow_detected   high while in ERROR
//   o_credit_error        one-cycle pulse: credit returned while already full
//   o_state[3:0]          one-hot state for observation:
//                         IDLE=0001 ACTIVE=0010 STALL=0100 ERROR=1000
//
// Handshake: a pop happens in every cycle o_buffer_read_enable is high; the
// TX buffer presents the popped word one cycle later, which is exactly the
// cycle o_tx_valid is high. There is no back-pressure from the link side;
// the credit counter is the only flow control.
// ---------------------------------------------------------------------------
module ucie_ctl_tx_fsm #(
  parameter int CREDIT_MAX = 8,
  parameter int CREDIT_W   = 4,
  parameter int ERR_HOLD   = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [3:0]          i_state_request,
  input  logic                i_buffer_empty,
  input  logic                i_credit_return,
  input  logic                i_overflow_detected,
  output logic                o_buffer_read_enable,
  output logic                o_tx_valid,
  output logic [CREDIT_W-1:0] o_credit_count,
  output logic                o_overflow_detected,
  output logic                o_credit_error,
  output logic [3:0]          o_state
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_ACTIVE = 4'b0010,
    ST_STALL  = 4'b0100,
    ST_ERROR  = 4'b1000
  } state_e;

  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_MAX);
  localparam int                  ERR_W       = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;
  localparam logic [ERR_W-1:0]    ERR_LAST    = ERR_W'(ERR_HOLD - 1);

  state_e              state_q,        state_d;
  logic [CREDIT_W-1:0] credit_q,       credit_d;
  logic [ERR_W-1:0]    err_cnt_q,      err_cnt_d;
  logic                tx_valid_q;
  logic                credit_error_q, credit_error_d;

  logic                issue;
  logic [CREDIT_W:0]   credit_sum;
  logic                credit_over;
  logic [CREDIT_W-1:0] credit_upd;

  // A read is issued only while ACTIVE with data and at least one credit.
  assign issue = (state_q == ST_ACTIVE) && !i_buffer_empty && (credit_q != '0);

  // One extra bit so a return at full count is visible as an overshoot.
  // issue implies credit_q != 0, so the subtraction cannot wrap.
  assign credit_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(i_credit_return)
                       - (CREDIT_W+1)'(issue);
  assign credit_over = credit_sum > {1'b0, CREDIT_FULL};
  assign credit_upd  = credit_over ? CREDIT_FULL : credit_sum[CREDIT_W-1:0];

  // -------------------------------------------------------------------------
  // Next-state / counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    err_cnt_d      = err_cnt_q;
    credit_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Credits are pinned at full and returns are ignored here.
        credit_d  = CREDIT_FULL;
        err_cnt_d = '0;
        if (i_state_request != 4'h0) begin
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE, ST_STALL: begin
        credit_d       = credit_upd;
        credit_error_d = credit_over;
        // Priority: overflow, then request drop, then credit conditions.
        if (i_overflow_detected) begin
          state_d   = ST_ERROR;
          err_cnt_d = '0;
        end else if (i_state_request == 4'h0) begin
          // Link-level drop flushes the remote buffer, so all credits return.
          state_d  = ST_IDLE;
          credit_d = CREDIT_FULL;
        end else if ((state_q == ST_ACTIVE) && (credit_upd == '0)) begin
          state_d = ST_STALL;
        end else if ((state_q == ST_STALL) && i_credit_return) begin
          state_d = ST_ACTIVE;
        end
      end

      ST_ERROR: begin
        // Fixed-length hold; request and overflow inputs are not looked at.
        if (err_cnt_q == ERR_LAST) begin
          state_d   = ST_IDLE;
          credit_d  = CREDIT_FULL;
          err_cnt_d = '0;
        end else begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        credit_d  = CREDIT_FULL;
        err_cnt_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= CREDIT_FULL;
      err_cnt_q      <= '0;
      tx_valid_q     <= 1'b0;
      credit_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      err_cnt_q      <= err_cnt_d;
      // Follows issue in every state so the last ACTIVE read still shows up.
      tx_valid_q     <= issue;
      credit_error_q <= credit_error_d;
    end
  end

  assign o_buffer_read_enable = issue;
  assign o_tx_valid           = tx_valid_q;
  assign o_credit_count       = credit_q;
  assign o_overflow_detected  = (state_q == ST_ERROR);
  assign o_credit_error       = credit_error_q;
  assign o_state              = state_q;

endmodule
